// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command-line decoder.
// Also provides a helper that recognises the two line terminators.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        TERM    = 3'd3,
        DISCARD = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UPPER_W = 8'h57;
    localparam logic [7:0] ASCII_LOWER_W = 8'h77;
    localparam logic [7:0] ASCII_UPPER_R = 8'h52;
    localparam logic [7:0] ASCII_LOWER_R = 8'h72;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_F = 8'h46;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_F = 8'h66;

    function automatic logic is_term(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_hex.sv
// Combinational ASCII hex digit decoder: 0-9, A-F and a-f map to a nibble.
// Any other byte reports is_hex = 0 with a zero nibble.
module hex_digit_decode
    import uart_cmd_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Letters share the low nibble pattern 1..6, so both cases add 9.
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if ((ascii >= ASCII_0) && (ascii <= ASCII_9)) begin
            nibble = ascii[3:0];
            is_hex = 1'b1;
        end else if (((ascii >= ASCII_UPPER_A) && (ascii <= ASCII_UPPER_F)) ||
                     ((ascii >= ASCII_LOWER_A) && (ascii <= ASCII_LOWER_F))) begin
            nibble = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end else begin
            nibble = 4'h0;
            is_hex = 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses ASCII "W<addr><data>" / "R<addr>" lines from a UART receiver into
// address/data commands with a valid/ready handshake and an error pulse.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              data_ready,
    input  logic              data_valid,
    input  logic [7:0]        data_byte,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_error
);

    localparam int ADDR_DIGITS = ADDR_W / 4;
    localparam int DATA_DIGITS = DATA_W / 4;
    localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CNT_W       = $clog2(MAX_DIGITS + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    state_t           state_r;
    logic [CNT_W-1:0] digit_cnt_r;
    logic [3:0]       nibble_s;
    logic             is_hex_s;
    logic             is_term_s;
    logic             accept_s;

    hex_digit_decode u_hex (
        .ascii  (data_byte),
        .nibble (nibble_s),
        .is_hex (is_hex_s)
    );

    assign is_term_s = is_term(data_byte);
    assign accept_s  = data_valid && data_ready;

    // Line parser; data_ready is kept as a registered decode of "next state is not HOLD".
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            digit_cnt_r <= CNT_ZERO;
            data_ready  <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_error   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= {ADDR_W{1'b0}};
            cmd_data    <= {DATA_W{1'b0}};
        end else begin
            cmd_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (is_term_s || (data_byte == ASCII_SPACE)) begin
                            state_r <= IDLE;
                        end else if ((data_byte == ASCII_UPPER_W) || (data_byte == ASCII_LOWER_W) ||
                                     (data_byte == ASCII_UPPER_R) || (data_byte == ASCII_LOWER_R)) begin
                            // Fresh command: clear fields so a read reports zero data.
                            state_r     <= ADDR;
                            cmd_write   <= (data_byte == ASCII_UPPER_W) || (data_byte == ASCII_LOWER_W);
                            cmd_addr    <= {ADDR_W{1'b0}};
                            cmd_data    <= {DATA_W{1'b0}};
                            digit_cnt_r <= CNT_ZERO;
                        end else begin
                            state_r   <= DISCARD;
                            cmd_error <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (accept_s) begin
                        if (is_hex_s) begin
                            cmd_addr <= ADDR_W'({cmd_addr, nibble_s});
                            if (digit_cnt_r == ADDR_LAST) begin
                                digit_cnt_r <= CNT_ZERO;
                                state_r     <= cmd_write ? DATA : TERM;
                            end else begin
                                digit_cnt_r <= digit_cnt_r + CNT_ONE;
                            end
                        end else if (is_term_s) begin
                            state_r   <= IDLE;
                            cmd_error <= 1'b1;
                        end else begin
                            state_r   <= DISCARD;
                            cmd_error <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (accept_s) begin
                        if (is_hex_s) begin
                            cmd_data <= DATA_W'({cmd_data, nibble_s});
                            if (digit_cnt_r == DATA_LAST) begin
                                digit_cnt_r <= CNT_ZERO;
                                state_r     <= TERM;
                            end else begin
                                digit_cnt_r <= digit_cnt_r + CNT_ONE;
                            end
                        end else if (is_term_s) begin
                            state_r   <= IDLE;
                            cmd_error <= 1'b1;
                        end else begin
                            state_r   <= DISCARD;
                            cmd_error <= 1'b1;
                        end
                    end
                end

                TERM: begin
                    if (accept_s) begin
                        if (is_term_s) begin
                            state_r    <= HOLD;
                            data_ready <= 1'b0;
                            cmd_valid  <= 1'b1;
                        end else begin
                            state_r   <= DISCARD;
                            cmd_error <= 1'b1;
                        end
                    end
                end

                DISCARD: begin
                    if (accept_s && is_term_s) begin
                        state_r <= IDLE;
                    end
                end

                HOLD: begin
                    if (cmd_ready) begin
                        state_r    <= IDLE;
                        cmd_valid  <= 1'b0;
                        data_ready <= 1'b1;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    digit_cnt_r <= CNT_ZERO;
                    data_ready  <= 1'b1;
                    cmd_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed line table, multi-cycle
// corner sequences, and random lines checked against a line-level model.
module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ready;
    logic        data_valid;
    logic [7:0]  data_byte;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_error;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_ready (data_ready),
        .data_valid (data_valid),
        .data_byte  (data_byte),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_error  (cmd_error)
    );

    typedef struct {
        bit          is_err;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        string       line;
        bit          exp_cmd;
        bit          exp_wr;
        logic [15:0] exp_addr;
        logic [31:0] exp_data;
        int          exp_err;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    bit   rand_ready_en = 1'b0;
    bit   ready_force = 1'b1;
    ev_t  obs_q[$];
    int   mon_viol = 0;
    ev_t  exp_q[$];
    vec_t vecs[$];
    logic [7:0] line_q[$];
    bit   in_line = 1'b0;
    logic [7:0] rl[$];

    // Downstream ready driver, offset from the data inputs so the two never race.
    always @(posedge clk) begin
        #2;
        cmd_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_force;
    end

    bit          prev_stall = 1'b0;
    bit          prev_rst = 1'b1;
    logic        pw;
    logic [15:0] pa;
    logic [31:0] pd;

    // Event monitor: records transfers and error pulses, flags handshake violations.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1)
            obs_q.push_back('{1'b0, cmd_write, cmd_addr, cmd_data});
        if (cmd_error === 1'b1)
            obs_q.push_back('{1'b1, 1'b0, 16'h0, 32'h0});
        if (cmd_valid === 1'b1 && data_ready !== 1'b0)
            mon_viol <= mon_viol + 1;
        if (prev_stall && !prev_rst &&
            !(cmd_valid === 1'b1 && cmd_write === pw && cmd_addr === pa && cmd_data === pd))
            mon_viol <= mon_viol + 1;
        prev_stall <= (cmd_valid === 1'b1) && (cmd_ready === 1'b0);
        prev_rst   <= reset;
        pw <= cmd_write;
        pa <= cmd_addr;
        pd <= cmd_data;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int waits);
        logic dr;
        waits = 0;
        data_valid = 1'b1;
        data_byte  = b;
        while (1) begin
            @(negedge clk);
            dr = data_ready;
            @(posedge clk);
            #1;
            if (dr === 1'b1) break;
            waits++;
            if (waits >= 200) begin
                check("byte_accept_timeout", 64'(waits), 64'(0));
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        int w;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], w);
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit is_eol(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    // Judge one complete line: command letter, then exactly the right count of hex digits.
    task automatic model_line();
        bit      ok = 1'b1;
        bit      wr = 1'b0;
        int      need = 0;
        longint  a = 0;
        longint  d = 0;
        int      v;
        if (line_q[0] == "W" || line_q[0] == "w") begin wr = 1'b1; need = 12; end
        else if (line_q[0] == "R" || line_q[0] == "r") begin wr = 1'b0; need = 4; end
        else ok = 1'b0;
        if (ok && (line_q.size() - 1 != need)) ok = 1'b0;
        for (int i = 1; ok && i < line_q.size(); i++) begin
            v = hexval(line_q[i]);
            if (v < 0) ok = 1'b0;
            else if (i <= 4) a = a * 16 + v;
            else d = d * 16 + v;
        end
        if (ok) exp_q.push_back('{1'b0, wr, 16'(a), 32'(d)});
        else    exp_q.push_back('{1'b1, 1'b0, 16'h0, 32'h0});
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!in_line) begin
            if (is_eol(b) || b == 8'h20) return;
            in_line = 1'b1;
            line_q.delete();
            line_q.push_back(b);
        end else if (is_eol(b)) begin
            model_line();
            in_line = 1'b0;
        end else begin
            line_q.push_back(b);
        end
    endtask

    task automatic rand_hex(output logic [7:0] c);
        int v;
        v = int'($urandom_range(0, 15));
        if (v < 10) c = 8'(48 + v);
        else c = $urandom_range(0, 1) ? 8'(55 + v) : 8'(87 + v);
    endtask

    task automatic gen_line();
        int kind;
        int nd;
        logic [7:0] c;
        rl.delete();
        repeat ($urandom_range(0, 2)) rl.push_back(8'h20);
        kind = int'($urandom_range(0, 9));
        if (kind == 9) begin
            repeat ($urandom_range(1, 5)) rl.push_back(8'($urandom_range(33, 126)));
        end else begin
            if (kind <= 3 || kind == 7) begin
                rl.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
                nd = 12;
            end else begin
                rl.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
                nd = 4;
            end
            for (int i = 0; i < nd; i++) begin
                rand_hex(c);
                rl.push_back(c);
            end
            if (kind == 7)
                rl[$urandom_range(0, rl.size() - 1)] = 8'($urandom_range(32, 126));
            if (kind == 8) begin
                if ($urandom_range(0, 1)) begin
                    rand_hex(c);
                    rl.push_back(c);
                end else begin
                    repeat ($urandom_range(1, 3)) void'(rl.pop_back());
                end
            end
        end
        rl.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
    endtask

    task automatic add_vec(input string l, input bit c, input bit w, input logic [15:0] a,
                           input logic [31:0] d, input int e);
        vec_t v;
        v.line = l; v.exp_cmd = c; v.exp_wr = w; v.exp_addr = a; v.exp_data = d; v.exp_err = e;
        vecs.push_back(v);
    endtask

    initial begin
        int base;
        int ncmd;
        int nerr;
        int w;
        int stall_bad;
        ev_t ce;

        add_vec("W1234DEADBEEF\015",       1'b1, 1'b1, 16'h1234, 32'hDEADBEEF, 0);
        add_vec("r00ff\n",                 1'b1, 1'b0, 16'h00FF, 32'h0,        0);
        add_vec("W12G4...\015",            1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("R0001\015",               1'b1, 1'b0, 16'h0001, 32'h0,        0);
        add_vec("W12\015",                 1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("R12345\015",              1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("R12345R0003\015",         1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("  \015\nw00aBcdEf0123\n", 1'b1, 1'b1, 16'h00AB, 32'hCDEF0123, 0);
        add_vec("X\015",                   1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("W1234DEADBEEF5\015",      1'b0, 1'b0, 16'h0,    32'h0,        1);
        add_vec("R12 4\n",                 1'b0, 1'b0, 16'h0,    32'h0,        1);

        reset = 1'b1;
        data_valid = 1'b0;
        data_byte = 8'h00;
        idle(3);
        check("reset_cmd_valid", 64'(cmd_valid), 64'(0));
        check("reset_cmd_error", 64'(cmd_error), 64'(0));
        check("reset_cmd_write", 64'(cmd_write), 64'(0));
        check("reset_cmd_addr",  64'(cmd_addr),  64'(0));
        check("reset_cmd_data",  64'(cmd_data),  64'(0));
        reset = 1'b0;
        check("ready_after_reset", 64'(data_ready), 64'(1));

        // Directed line table with the consumer always ready.
        ready_force = 1'b1;
        idle(2);
        for (int i = 0; i < vecs.size(); i++) begin
            base = obs_q.size();
            send_str(vecs[i].line);
            idle(4);
            ncmd = 0;
            nerr = 0;
            for (int k = base; k < obs_q.size(); k++) begin
                if (obs_q[k].is_err) nerr++;
                else begin ncmd++; ce = obs_q[k]; end
            end
            check($sformatf("vec%0d_cmds", i), 64'(ncmd), 64'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_errs", i), 64'(nerr), 64'(vecs[i].exp_err));
            if (vecs[i].exp_cmd && ncmd == 1) begin
                check($sformatf("vec%0d_write", i), 64'(ce.wr),   64'(vecs[i].exp_wr));
                check($sformatf("vec%0d_addr", i),  64'(ce.addr), 64'(vecs[i].exp_addr));
                check($sformatf("vec%0d_data", i),  64'(ce.data), 64'(vecs[i].exp_data));
            end
        end

        // Latency of cmd_valid and width of the error pulse.
        send_str("R0010");
        send_byte(8'h0D, w);
        check("latency_valid_high", 64'(cmd_valid), 64'(1));
        check("latency_ready_low",  64'(data_ready), 64'(0));
        idle(1);
        check("transfer_valid_low", 64'(cmd_valid), 64'(0));
        check("transfer_ready_high", 64'(data_ready), 64'(1));
        send_byte("Q", w);
        check("err_pulse_high", 64'(cmd_error), 64'(1));
        idle(1);
        check("err_pulse_low", 64'(cmd_error), 64'(0));
        send_byte(8'h0D, w);
        idle(2);

        // Consumer stalls for 20 cycles; outputs must hold.
        ready_force = 1'b0;
        idle(1);
        base = obs_q.size();
        send_str("W1234DEADBEEF\015");
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (!(cmd_valid === 1'b1 && data_ready === 1'b0 && cmd_write === 1'b1 &&
                  cmd_addr === 16'h1234 && cmd_data === 32'hDEADBEEF)) stall_bad++;
        end
        check("stall_outputs_held", 64'(stall_bad), 64'(0));
        check("stall_no_transfer", 64'(obs_q.size() - base), 64'(0));
        ready_force = 1'b1;
        idle(1);
        check("stall_release_valid", 64'(cmd_valid), 64'(0));
        check("stall_release_count", 64'(obs_q.size() - base), 64'(1));
        if (obs_q.size() - base == 1)
            check("stall_release_cmd", {14'h0, obs_q[base].is_err, obs_q[base].wr, obs_q[base].addr, obs_q[base].data},
                  {14'h0, 1'b0, 1'b1, 16'h1234, 32'hDEADBEEF});

        // Back-to-back lines: next byte waits exactly the one HOLD cycle.
        base = obs_q.size();
        send_str("R0001");
        send_byte(8'h0D, w);
        send_byte("R", w);
        check("back_to_back_wait", 64'(w), 64'(1));
        send_str("0002\015");
        idle(3);
        check("back_to_back_count", 64'(obs_q.size() - base), 64'(2));

        // Reset in the middle of a line.
        base = obs_q.size();
        send_str("W12");
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        check("midline_reset_quiet", 64'(obs_q.size() - base), 64'(0));
        send_str("R0010\015");
        idle(3);
        check("midline_reset_next_count", 64'(obs_q.size() - base), 64'(1));
        if (obs_q.size() - base == 1)
            check("midline_reset_next_cmd", {14'h0, obs_q[base].is_err, obs_q[base].wr, obs_q[base].addr, obs_q[base].data},
                  {14'h0, 1'b0, 1'b0, 16'h0010, 32'h0});

        // Reset while holding a command.
        ready_force = 1'b0;
        idle(1);
        base = obs_q.size();
        send_str("R0020\015");
        check("hold_before_reset", 64'(cmd_valid), 64'(1));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("hold_reset_valid", 64'(cmd_valid), 64'(0));
        check("hold_reset_addr", 64'(cmd_addr), 64'(0));
        ready_force = 1'b1;
        idle(3);
        check("hold_reset_quiet", 64'(obs_q.size() - base), 64'(0));

        // Random lines against the line-level model, random consumer backpressure.
        rand_ready_en = 1'b1;
        idle(1);
        base = obs_q.size();
        exp_q.delete();
        in_line = 1'b0;
        repeat (150) begin
            gen_line();
            foreach (rl[j]) begin
                model_byte(rl[j]);
                send_byte(rl[j], w);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        rand_ready_en = 1'b0;
        ready_force = 1'b1;
        idle(10);
        check("rand_event_count", 64'(obs_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (base + i) < obs_q.size(); i++)
            check($sformatf("rand_event%0d", i),
                  {14'h0, obs_q[base + i].is_err, obs_q[base + i].wr, obs_q[base + i].addr, obs_q[base + i].data},
                  {14'h0, exp_q[i].is_err, exp_q[i].wr, exp_q[i].addr, exp_q[i].data});

        check("handshake_monitor", 64'(mon_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
